vga_timing_ctrl: RTL and testbench

//  Generates VGA raster timing and sequences the image-storage datapath: sync pulses,

---
 rtl/vga_timing_ctrl_pkg.sv | 33 +++
 rtl/vga_timing_ctrl_if.sv | 31 +++
 rtl/vga_timing_ctrl_raster_axis_counter.sv | 45 ++++
 rtl/vga_timing_ctrl.sv | 106 ++++++++++
 tb/tb_vga_timing_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_ctrl_pkg.sv
// Shared constants and helpers for the VGA raster timing slice.
// Holds the 640x480@60 default timing, the coordinate width and small helpers
// used to derive axis totals and sync levels.
package vga_timing_ctrl_pkg;

  localparam int unsigned COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;

  // 640x480@60 defaults
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  function automatic int unsigned axis_total(int unsigned active, int unsigned fp,
                                             int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Drive level of a sync line given whether its window is active.
  function automatic logic sync_level(logic active, logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bundle between the timing controller and the image store / DAC.
//   ENABLE               : run/freeze request from the consumer side
//   HSYNC, VSYNC         : sync pulses (polarity set by the controller)
//   VIDEO_ON             : decoded position is visible
//   PIX_CE               : one-CLK pulse per visible pixel
//   FRAME_START          : one-CLK pulse at position (0,0)
//   PIX_X, PIX_Y         : decoded raster position
// master = timing controller, slave = consumer.
interface vga_timing_ctrl_if;
  import vga_timing_ctrl_pkg::*;

  logic   ENABLE;
  logic   HSYNC;
  logic   VSYNC;
  logic   VIDEO_ON;
  logic   PIX_CE;
  logic   FRAME_START;
  coord_t PIX_X;
  coord_t PIX_Y;

  modport master (
    input  ENABLE,
    output HSYNC, VSYNC, VIDEO_ON, PIX_CE, FRAME_START, PIX_X, PIX_Y
  );

  modport slave (
    output ENABLE,
    input  HSYNC, VSYNC, VIDEO_ON, PIX_CE, FRAME_START, PIX_X, PIX_Y
  );

endinterface

// File: rtl/vga_timing_ctrl_raster_axis_counter.sv
// One raster axis (horizontal or vertical): a wrap counter 0..TOTAL-1 that
// advances when inc is high, with combinational decode of its current value.
//   CLK, RESET  : clock, synchronous active-high reset
//   inc         : advance by one (wraps TOTAL-1 -> 0)
//   count       : current position
//   tc          : count is at TOTAL-1 (wrap happens on next inc)
//   sync_win    : count inside the sync window
//   active_win  : count inside the visible window
module raster_axis_counter
  import vga_timing_ctrl_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP
) (
  input  logic   CLK,
  input  logic   RESET,
  input  logic   inc,
  output coord_t count,
  output logic   tc,
  output logic   sync_win,
  output logic   active_win
);

  localparam coord_t LAST       = coord_t'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
  localparam coord_t ACTIVE_END = coord_t'(ACTIVE);
  localparam coord_t SYNC_BEG   = coord_t'(ACTIVE + FP);
  localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

  always_comb begin
    tc         = (count == LAST);
    sync_win   = (count >= SYNC_BEG) && (count < SYNC_END);
    active_win = (count < ACTIVE_END);
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing controller.
// Divides CLK down to a pixel tick, walks the H/V raster counters and registers
// the decoded position onto the timing bundle one pixel after the counters.
//   CLK    : system clock
//   RESET  : synchronous active-high reset (overrides ENABLE)
//   vga    : master side of vga_timing_ctrl_if (ENABLE in; syncs, VIDEO_ON,
//            PIX_CE, FRAME_START, PIX_X, PIX_Y out)
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic CLK,
  input  logic RESET,
  vga_timing_ctrl_if.master vga
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tick;
  coord_t           h_count, v_count;
  logic             h_tc, h_sync, h_act;
  logic             v_sync, v_act;
  logic             v_tc_unused;
  logic             visible;

  assign tick    = vga.ENABLE && (div == DIV_LAST);
  assign visible = h_act && v_act;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div <= '0;
    end else if (vga.ENABLE) begin
      div <= tick ? '0 : div + 1'b1;
    end
  end

  raster_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h (
    .CLK        (CLK),
    .RESET      (RESET),
    .inc        (tick),
    .count      (h_count),
    .tc         (h_tc),
    .sync_win   (h_sync),
    .active_win (h_act)
  );

  // V wraps in the same tick as the H wrap because its tc is not consulted here:
  // it simply advances on every H wrap and its own wrap is internal.
  raster_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v (
    .CLK        (CLK),
    .RESET      (RESET),
    .inc        (tick && h_tc),
    .count      (v_count),
    .tc         (v_tc_unused),
    .sync_win   (v_sync),
    .active_win (v_act)
  );

  // Output stage: captures the position being left on each tick, so every
  // output describes the same pixel. Strobes are single-CLK.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vga.PIX_X       <= '0;
      vga.PIX_Y       <= '0;
      vga.VIDEO_ON    <= 1'b0;
      vga.PIX_CE      <= 1'b0;
      vga.FRAME_START <= 1'b0;
      vga.HSYNC       <= ~SYNC_POL;
      vga.VSYNC       <= ~SYNC_POL;
    end else if (tick) begin
      vga.PIX_X       <= h_count;
      vga.PIX_Y       <= v_count;
      vga.VIDEO_ON    <= visible;
      vga.PIX_CE      <= visible;
      vga.FRAME_START <= (h_count == '0) && (v_count == '0);
      vga.HSYNC       <= sync_level(h_sync, SYNC_POL);
      vga.VSYNC       <= sync_level(v_sync, SYNC_POL);
    end else begin
      vga.PIX_CE      <= 1'b0;
      vga.FRAME_START <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
module tb_vga_timing_ctrl;

  typedef struct packed {
    logic        hs, vs, vid, ce, fs;
    logic [10:0] x, y;
  } outs_t;

  typedef struct {
    int unsigned div, h, v;
    outs_t       o;
  } mdl_t;

  typedef struct {
    bit    rst, en;
    outs_t exp;
  } vec_t;

  logic       CLK = 1'b0;
  logic [2:0] rst_s = '1;
  logic [2:0] en_s  = '0;

  always #5 CLK = ~CLK;

  vga_timing_ctrl_if if1 ();
  vga_timing_ctrl_if if4 ();
  vga_timing_ctrl_if ifp ();

  assign if1.ENABLE = en_s[0];
  assign if4.ENABLE = en_s[1];
  assign ifp.ENABLE = en_s[2];

  vga_timing_ctrl #(.CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0))
    u1 (.CLK(CLK), .RESET(rst_s[0]), .vga(if1));
  vga_timing_ctrl #(.CLK_DIV(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0))
    u4 (.CLK(CLK), .RESET(rst_s[1]), .vga(if4));
  vga_timing_ctrl #(.CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1))
    up (.CLK(CLK), .RESET(rst_s[2]), .vga(ifp));

  outs_t act [3];
  assign act[0] = {if1.HSYNC, if1.VSYNC, if1.VIDEO_ON, if1.PIX_CE, if1.FRAME_START, if1.PIX_X, if1.PIX_Y};
  assign act[1] = {if4.HSYNC, if4.VSYNC, if4.VIDEO_ON, if4.PIX_CE, if4.FRAME_START, if4.PIX_X, if4.PIX_Y};
  assign act[2] = {ifp.HSYNC, ifp.VSYNC, ifp.VIDEO_ON, ifp.PIX_CE, ifp.FRAME_START, ifp.PIX_X, ifp.PIX_Y};

  int n_cmp = 0;
  int n_bad = 0;
  mdl_t  m [3];
  outs_t sbq0 [$];
  outs_t sbq1 [$];
  outs_t sbq2 [$];
  int unsigned cdiv [3] = '{1, 4, 1};
  bit          pol  [3] = '{1'b0, 1'b0, 1'b1};

  // Reference raster: H_TOTAL 8 (4/1/2/1), V_TOTAL 6 (3/1/1/1).
  function automatic mdl_t mstep(mdl_t s, bit rst, bit en, int unsigned cd, bit p);
    mdl_t n;
    bit   tick;
    n = s;
    if (rst) begin
      n.div = 0; n.h = 0; n.v = 0;
      n.o.x = '0; n.o.y = '0; n.o.vid = 1'b0; n.o.ce = 1'b0; n.o.fs = 1'b0;
      n.o.hs = ~p; n.o.vs = ~p;
      return n;
    end
    tick = en && (s.div == cd - 1);
    if (en) n.div = tick ? 0 : s.div + 1;
    n.o.ce = 1'b0;
    n.o.fs = 1'b0;
    if (tick) begin
      n.o.x   = 11'(s.h);
      n.o.y   = 11'(s.v);
      n.o.vid = (s.h < 4) && (s.v < 3);
      n.o.ce  = (s.h < 4) && (s.v < 3);
      n.o.fs  = (s.h == 0) && (s.v == 0);
      n.o.hs  = (s.h == 5 || s.h == 6) ? p : ~p;
      n.o.vs  = (s.v == 4) ? p : ~p;
      n.h = (s.h == 7) ? 0 : s.h + 1;
      if (s.h == 7) n.v = (s.v == 5) ? 0 : s.v + 1;
    end
    return n;
  endfunction

  task automatic check_o(string nm, outs_t got, outs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic check_i(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // One clock: push model expectations, take the edge, pop and compare.
  task automatic cycle();
    for (int k = 0; k < 3; k++) m[k] = mstep(m[k], rst_s[k], en_s[k], cdiv[k], pol[k]);
    sbq0.push_back(m[0].o);
    sbq1.push_back(m[1].o);
    sbq2.push_back(m[2].o);
    @(posedge CLK);
    #1;
    check_o("sb_div1",  act[0], sbq0.pop_front());
    check_o("sb_div4",  act[1], sbq1.pop_front());
    check_o("sb_polhi", act[2], sbq2.pop_front());
  endtask

  function automatic outs_t mk(bit hs, bit vs, bit vid, bit ce, bit fs, int x, int y);
    outs_t o;
    o.hs = hs; o.vs = vs; o.vid = vid; o.ce = ce; o.fs = fs;
    o.x = 11'(x); o.y = 11'(y);
    return o;
  endfunction

  vec_t vecs [14];

  initial begin
    int last_fs, last_ce4, last_ce4_y, last_x4, last_xchg;
    int ce1_cnt, vs1_cnt, ce4_cnt, bad_hs1, bad_hsp;
    bit found;

    for (int k = 0; k < 3; k++) begin
      m[k].div = 0; m[k].h = 0; m[k].v = 0; m[k].o = '0;
    end

    // Hand-derived per-cycle expectations for the CLK_DIV=1, active-low instance.
    vecs[0]  = '{1'b1, 1'b1, mk(1,1,0,0,0, 0,0)};
    vecs[1]  = '{1'b0, 1'b1, mk(1,1,1,1,1, 0,0)};
    vecs[2]  = '{1'b0, 1'b1, mk(1,1,1,1,0, 1,0)};
    vecs[3]  = '{1'b0, 1'b1, mk(1,1,1,1,0, 2,0)};
    vecs[4]  = '{1'b0, 1'b1, mk(1,1,1,1,0, 3,0)};
    vecs[5]  = '{1'b0, 1'b1, mk(1,1,0,0,0, 4,0)};
    vecs[6]  = '{1'b0, 1'b1, mk(0,1,0,0,0, 5,0)};
    vecs[7]  = '{1'b0, 1'b1, mk(0,1,0,0,0, 6,0)};
    vecs[8]  = '{1'b0, 1'b1, mk(1,1,0,0,0, 7,0)};
    vecs[9]  = '{1'b0, 1'b1, mk(1,1,1,1,0, 0,1)};
    vecs[10] = '{1'b0, 1'b0, mk(1,1,1,0,0, 0,1)};
    vecs[11] = '{1'b0, 1'b1, mk(1,1,1,1,0, 1,1)};
    vecs[12] = '{1'b1, 1'b1, mk(1,1,0,0,0, 0,0)};
    vecs[13] = '{1'b0, 1'b1, mk(1,1,1,1,1, 0,0)};

    @(negedge CLK);
    for (int i = 0; i < 14; i++) begin
      rst_s = {3{vecs[i].rst}};
      en_s  = {3{vecs[i].en}};
      cycle();
      check_o($sformatf("vec%0d", i), act[0], vecs[i].exp);
    end

    // Free run from a fresh reset: two CLK_DIV=4 frames.
    rst_s = '1; en_s = '1;
    cycle();
    rst_s = '0;
    last_fs = -1; last_ce4 = -1; last_ce4_y = -1; last_x4 = 0; last_xchg = -1;
    ce1_cnt = 0; vs1_cnt = 0; ce4_cnt = 0; bad_hs1 = 0; bad_hsp = 0;
    for (int t = 0; t < 384; t++) begin
      cycle();
      if (act[0].fs) begin
        if (last_fs >= 0) check_i("fs_period", t - last_fs, 48);
        last_fs = t;
      end
      if (t < 48 && act[0].ce) ce1_cnt++;
      if (t < 48 && !act[0].vs) vs1_cnt++;
      if ((act[0].hs == 1'b0) != (act[0].x == 5 || act[0].x == 6)) bad_hs1++;
      if ((act[2].hs == 1'b1) != (act[2].x == 5 || act[2].x == 6)) bad_hsp++;
      if (t < 192 && act[1].ce) ce4_cnt++;
      if (act[1].ce) begin
        if (last_ce4 >= 0 && int'(act[1].y) == last_ce4_y && act[1].x != 0)
          check_i("ce4_gap", t - last_ce4, 4);
        last_ce4 = t;
        last_ce4_y = int'(act[1].y);
      end
      if (t < 40 && int'(act[1].x) != last_x4) begin
        if (last_xchg >= 0) check_i("x4_step", t - last_xchg, 4);
        last_xchg = t;
        last_x4 = int'(act[1].x);
      end
    end
    check_i("ce_per_frame_div1", ce1_cnt, 12);
    check_i("vsync_low_cycles", vs1_cnt, 8);
    check_i("hsync_window_lo", bad_hs1, 0);
    check_i("hsync_window_hi", bad_hsp, 0);
    check_i("ce_per_frame_div4", ce4_cnt, 12);

    // Freeze at PIX_X=2, resume must decode 3.
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      cycle();
      if (act[0].x == 2 && act[0].ce) found = 1'b1;
    end
    check_i("wait_x2", int'(found), 1);
    en_s[0] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      cycle();
      check_i("frz_ce", int'(act[0].ce), 0);
      check_i("frz_x", int'(act[0].x), 2);
    end
    en_s[0] = 1'b1;
    cycle();
    check_i("resume_x", int'(act[0].x), 3);

    // Reset while VSYNC is active.
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      cycle();
      if (act[0].y == 4 && !act[0].vs) found = 1'b1;
    end
    check_i("wait_y4", int'(found), 1);
    rst_s[0] = 1'b1;
    cycle();
    check_o("rst_in_vsync", act[0], mk(1,1,0,0,0, 0,0));
    rst_s[0] = 1'b0;
    cycle();
    check_o("first_after_rst", act[0], mk(1,1,1,1,1, 0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
